// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages with bubble collapse,
// synchronous flush and an occupancy count.
module dff_pipe #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 4,
    parameter bit               DATA_RST = 1'b1,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    input  logic [WIDTH-1:0]           d_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    output logic [WIDTH-1:0]           q_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            valid_reg;
    logic [DEPTH-1:0][WIDTH-1:0] data_reg;
    logic [DEPTH-1:0][WIDTH-1:0] stage_in;
    logic [DEPTH:0]              rdy;
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0]            leave;
    logic                        move_en;

    assign move_en    = !reset && !flush_i;
    assign rdy[DEPTH] = out_ready_i;
    assign in_ready_o = rdy[0] && move_en;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            // A stage can take a beat if it or any stage downstream has a
            // hole, or the consumer is draining the tail this cycle.
            assign rdy[gi]   = !(&valid_reg[DEPTH-1:gi]) || out_ready_i;
            assign leave[gi] = valid_reg[gi] && rdy[gi+1];
            if (gi == 0) begin : g_head
                assign load[gi]     = in_valid_i && in_ready_o;
                assign stage_in[gi] = d_i;
            end else begin : g_body
                assign load[gi]     = valid_reg[gi-1] && rdy[gi] && move_en;
                assign stage_in[gi] = data_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (reset || flush_i) begin
                valid_reg[k] <= 1'b0;
            end else if (load[k]) begin
                valid_reg[k] <= 1'b1;
            end else if (leave[k]) begin
                valid_reg[k] <= 1'b0;
            end
        end
    end

    // Data only moves on a load; flush leaves contents in place.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (reset && DATA_RST) begin
                data_reg[k] <= RST_VAL;
            end else if (load[k]) begin
                data_reg[k] <= stage_in[k];
            end
        end
    end

    always_comb begin
        count_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_o = count_o + CW'(valid_reg[k]);
        end
    end

    assign out_valid_o = valid_reg[DEPTH-1];
    assign q_o         = data_reg[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Randomized and directed bench for dff_pipe: three instances (DEPTH=4 with and
// without data reset, DEPTH=1) each checked against a queue-of-beats model.
module tb_dff_pipe;

    logic       clk;
    logic       reset;
    logic       flush_i;
    logic       in_valid_i;
    logic [7:0] d_i;
    logic       out_ready_i;

    logic       rdy_a, ov_a, rdy_b, ov_b, rdy_c, ov_c;
    logic [7:0] q_a, q_b, q_c;
    logic [2:0] cnt_a, cnt_b;
    logic [0:0] cnt_c;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Model per instance: ordered beats with their stage position.
    int         m_cnt   [3];
    int         m_pos   [3][4];
    logic [7:0] m_dat   [3][4];
    logic [7:0] m_qlast [3];
    logic       m_known [3];

    dff_pipe #(.WIDTH(8), .DEPTH(4), .DATA_RST(1'b1), .RST_VAL(8'h5A)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .d_i(d_i), .in_ready_o(rdy_a), .out_valid_o(ov_a), .q_o(q_a),
        .out_ready_i(out_ready_i), .count_o(cnt_a)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(4), .DATA_RST(1'b0), .RST_VAL(8'h5A)) dut_nr (
        .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .d_i(d_i), .in_ready_o(rdy_b), .out_valid_o(ov_b), .q_o(q_b),
        .out_ready_i(out_ready_i), .count_o(cnt_b)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1), .DATA_RST(1'b1), .RST_VAL(8'h00)) dut1 (
        .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .d_i(d_i), .in_ready_o(rdy_c), .out_valid_o(ov_c), .q_o(q_c),
        .out_ready_i(out_ready_i), .count_o(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cycle, got, exp);
        end
    endtask

    task automatic model_step(input int m, input int depth, input logic drst,
                              input logic [7:0] rstval, input logic o_rdy,
                              input logic o_ov, input logic [7:0] o_q,
                              input int o_cnt, input string nm);
        logic e_rdy, e_ov, dlv, acc;
        int   lim, p;
        e_rdy = !reset && !flush_i && (m_cnt[m] < depth || out_ready_i);
        e_ov  = (m_cnt[m] > 0) && (m_pos[m][0] == depth - 1);
        chk({nm, ".in_ready"}, 32'(o_rdy), 32'(e_rdy));
        chk({nm, ".out_valid"}, 32'(o_ov), 32'(e_ov));
        chk({nm, ".count"}, o_cnt, m_cnt[m]);
        if (m_known[m]) chk({nm, ".q"}, 32'(o_q), 32'(m_qlast[m]));

        if (reset || flush_i) begin
            if (m == 0) $display("cyc=%0d %s %s: pipeline cleared", cycle, nm,
                                 reset ? "reset" : "flush");
            m_cnt[m] = 0;
            if (reset && drst) begin
                m_qlast[m] = rstval;
                m_known[m] = 1'b1;
            end
        end else begin
            dlv = e_ov && out_ready_i;
            acc = in_valid_i && e_rdy;
            if (m == 0 && (dlv || acc))
                $display("cyc=%0d %s acc=%0b in=%h dlv=%0b out=%h", cycle, nm,
                         acc, d_i, dlv, m_dat[m][0]);
            if (dlv) begin
                for (int i = 0; i < m_cnt[m] - 1; i++) begin
                    m_pos[m][i] = m_pos[m][i+1];
                    m_dat[m][i] = m_dat[m][i+1];
                end
                m_cnt[m]--;
            end
            if (acc) begin
                m_pos[m][m_cnt[m]] = -1;
                m_dat[m][m_cnt[m]] = d_i;
                m_cnt[m]++;
            end
            // Every beat moves one stage closer, but never past the slot
            // its older neighbours leave free for it.
            for (int i = 0; i < m_cnt[m]; i++) begin
                lim = depth - 1 - i;
                p   = m_pos[m][i] + 1;
                m_pos[m][i] = (p < lim) ? p : lim;
            end
            if (m_cnt[m] > 0 && m_pos[m][0] == depth - 1) begin
                m_qlast[m] = m_dat[m][0];
                m_known[m] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step(0, 4, 1'b1, 8'h5A, rdy_a, ov_a, q_a, int'(cnt_a), "d4r");
        model_step(1, 4, 1'b0, 8'h5A, rdy_b, ov_b, q_b, int'(cnt_b), "d4n");
        model_step(2, 1, 1'b1, 8'h00, rdy_c, ov_c, q_c, int'(cnt_c), "d1");
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int m = 0; m < 3; m++) begin
            m_cnt[m]   = 0;
            m_qlast[m] = 8'h00;
            m_known[m] = 1'b0;
        end
        reset = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; d_i = 8'h00; out_ready_i = 1'b0;
        step();
        step();
        reset = 1'b0;
        idle(2);

        // streaming at full rate
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            d_i = 8'(8'h11 * (i + 1));
            step();
        end
        idle(6);

        // back-pressure: five pushes, four fit
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1;
            d_i = 8'(8'hA1 + i);
            step();
        end
        in_valid_i = 1'b0;
        idle(2);
        out_ready_i = 1'b1;
        idle(6);

        // bubble collapse of a lone beat
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; d_i = 8'hA5;
        step();
        idle(6);
        out_ready_i = 1'b1;
        idle(3);

        // flush with a simultaneous input beat
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            d_i = 8'(8'hC1 + i);
            step();
        end
        flush_i = 1'b1; in_valid_i = 1'b1; d_i = 8'hEE; out_ready_i = 1'b1;
        step();
        flush_i = 1'b0;
        idle(3);

        // mid-stream reset with a beat parked in the last stage
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            d_i = 8'(8'h61 + i);
            step();
        end
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        idle(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(1);
        out_ready_i = 1'b1;
        in_valid_i = 1'b1; d_i = 8'h77;
        step();
        idle(6);

        // random stress with shifting back-pressure bias and rare flushes
        for (int i = 0; i < 1000; i++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            d_i         = 8'($urandom);
            out_ready_i = ($urandom_range(0, 3) < ((i / 250) % 4 + 1));
            flush_i     = ($urandom_range(0, 79) == 0);
            step();
        end
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, legal range 1 or greater.
REQ-002 SHALL have parameter DEPTH, default 4: number of register stages, legal range 1 or greater.
REQ-003 SHALL have parameter DATA_RST, default 1: 1 = data registers load RST_VAL on reset; 0 = data registers are non-resettable and only valid bits reset.
REQ-004 SHALL have parameter RST_VAL, default '0: reset value of the data registers when DATA_RST=1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have port flush_i, input, 1 bit: synchronous discard of all pipeline contents.
REQ-008 SHALL have port in_valid_i, input, 1 bit: d_i holds a valid beat.
REQ-009 SHALL have port d_i, input, WIDTH bits: input data.
REQ-010 SHALL have port in_ready_o, output, 1 bit: the pipeline accepts a beat this cycle.
REQ-011 SHALL have port out_valid_o, output, 1 bit: q_o holds a valid beat.
REQ-012 SHALL have port q_o, output, WIDTH bits: output data, driven by the last stage.
REQ-013 SHALL have port out_ready_i, input, 1 bit: the consumer accepts a beat this cycle.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH+1) bits: number of valid stages.

Function
REQ-015 SHALL implement DEPTH stages, each holding one WIDTH-bit data register and one valid bit; stage DEPTH-1 drives q_o and out_valid_o.
REQ-016 SHALL transfer a beat on input when in_valid_i && in_ready_o, and on output when out_valid_o && out_ready_i, both sampled at the rising edge of clk.
REQ-017 SHALL advance stage k into stage k+1 when stage k is valid and stage k+1 is empty or advancing in the same cycle; readiness propagates combinationally from out_ready_i back to in_ready_o.
REQ-018 SHALL give a latency of exactly DEPTH cycles from input acceptance to out_valid_o for that beat when out_ready_i is held high, with throughput of one beat per cycle.
REQ-019 SHALL, when out_ready_i is low, compact beats forward into empty stages (bubble collapse) and hold valid stages, so that up to DEPTH beats are stored.
REQ-020 SHALL hold in_ready_o low when all DEPTH stages are valid and out_ready_i is low; in_ready_o SHALL be high when any stage is empty or the pipeline is draining.
REQ-021 SHALL preserve data order and never drop or duplicate a beat.
REQ-022 SHALL keep a stage's data register unchanged when it is not loaded (clock-enable behaviour), regardless of DATA_RST.
REQ-023 SHALL drive count_o as the popcount of the stage valid bits, updated at every clock edge and ranging from 0 to DEPTH.
REQ-024 SHALL, when flush_i is high, clear all valid bits at the next edge, force in_ready_o low, and accept no input; data registers SHALL be left unchanged.
REQ-025 SHALL give flush_i priority over simultaneous in_valid_i and out_ready_i; a beat presented in a flush cycle SHALL be neither accepted nor delivered.
REQ-026 SHALL, with DEPTH=1, behave as a single register that accepts new data in the same cycle its current beat is consumed.

Reset
REQ-027 SHALL, with reset high at a rising edge, clear all valid bits, so that out_valid_o=0 and count_o=0 after that edge.
REQ-028 SHALL, on reset with DATA_RST=1, load all data registers with RST_VAL, so that q_o=RST_VAL; with DATA_RST=0, data registers SHALL hold their previous value.
REQ-029 SHALL hold in_ready_o low while reset is high, and give reset priority over flush_i and all handshakes.
REQ-030 SHALL, on reset asserted mid-stream, discard all in-flight beats; the first beat accepted after reset deassertion SHALL emerge DEPTH cycles later.

Verification
REQ-031 SHALL cover streaming: DEPTH=4, out_ready_i=1, input beats 0x11, 0x22, 0x33 on consecutive cycles -> q_o shows 0x11, 0x22, 0x33 on consecutive cycles, with 0x11 first valid 4 cycles after acceptance.
REQ-032 SHALL cover back-pressure: out_ready_i=0, push 5 beats -> 4 accepted, count_o=4, in_ready_o=0 on the 5th; raise out_ready_i -> all 4 beats delivered in order.
REQ-033 SHALL cover bubble collapse: single beat 0xA5 pushed with out_ready_i=0 -> after 4 cycles out_valid_o=1, q_o=0xA5, count_o=1, and q_o stays stable until out_ready_i rises.
REQ-034 SHALL cover flush: pipeline holding 3 beats, flush_i=1 together with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0, and the input beat is not accepted.
REQ-035 SHALL cover mid-stream reset: DATA_RST=1, RST_VAL=0x5A, reset=1 for one edge -> out_valid_o=0, q_o=0x5A, count_o=0; with DATA_RST=0, q_o retains its last value.
REQ-036 SHALL cover random stress: random in_valid_i and out_ready_i over 1000 cycles against a queue model -> zero ordering, loss or duplication errors, and count_o always matches the model occupancy.
